// File: rtl/floo_pkg.sv
// Shared types for the FlooNoC end-of-simulation monitor.
// Benches import this to decode the monitor state.
package floo_pkg;

  typedef enum logic [1:0] {
    EosIdle,
    EosRun,
    EosDone,
    EosTimeout
  } eos_state_e;

endpackage

// File: rtl/floo_eos_monitor_if.sv
// Bundle of run-control inputs and status outputs of the EOS monitor.
// master = test harness, slave = monitor.
interface floo_eos_monitor_if #(
  parameter int unsigned NumChannels = 8,
  parameter int unsigned CntWidth    = 32
);

  logic                            start_i;
  logic [NumChannels-1:0]          done_i;
  logic [NumChannels-1:0]          progress_i;
  logic [NumChannels-1:0]          done_mask_o;
  logic [NumChannels*CntWidth-1:0] beat_cnt_o;
  logic [CntWidth-1:0]             runtime_o;
  logic                            all_done_o;
  logic                            timeout_o;
  logic [NumChannels-1:0]          stalled_mask_o;

  modport master (
    output start_i,
    output done_i,
    output progress_i,
    input  done_mask_o,
    input  beat_cnt_o,
    input  runtime_o,
    input  all_done_o,
    input  timeout_o,
    input  stalled_mask_o
  );

  modport slave (
    input  start_i,
    input  done_i,
    input  progress_i,
    output done_mask_o,
    output beat_cnt_o,
    output runtime_o,
    output all_done_o,
    output timeout_o,
    output stalled_mask_o
  );

endinterface

// File: rtl/floo_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
// Clear takes priority over enable.
module floo_sat_counter #(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [CntWidth-1:0] cnt_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/floo_eos_monitor.sv
// End-of-simulation and progress monitor: latches per-channel done
// flags, counts beats, and raises a timeout when the network goes idle.
module floo_eos_monitor
  import floo_pkg::*;
#(
  parameter int unsigned NumChannels   = 8,
  parameter int unsigned TimeoutCycles = 10000,
  parameter int unsigned CntWidth      = 32
) (
  input logic              clk_i,
  input logic              rst_ni,
  floo_eos_monitor_if.slave mon
);

  localparam logic [CntWidth-1:0] WdMax  =
    CntWidth'(TimeoutCycles);
  localparam logic [CntWidth-1:0] WdLast =
    CntWidth'(TimeoutCycles - 1);

  eos_state_e             state_q, state_d;
  logic [NumChannels-1:0] mask_q, mask_d;
  logic [NumChannels-1:0] stall_q, stall_d;
  logic [CntWidth-1:0]    wd_q, wd_d;
  logic                   all_done_q, timeout_q;
  logic [NumChannels-1:0] new_done;
  logic                   act, to_hit, run_en;

  logic [NumChannels-1:0][CntWidth-1:0] beat_cnt;
  logic [CntWidth-1:0]                  runtime;

  assign new_done = mon.done_i & ~mask_q;
  assign act      = (|mon.progress_i) | (|new_done);
  assign to_hit   = (TimeoutCycles != 0) &&
                    (wd_q == WdLast) && !act;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    wd_d    = wd_q;
    run_en  = 1'b0;
    if (mon.start_i) begin
      state_d = EosRun;
      mask_d  = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        EosRun: begin
          run_en = 1'b1;
          mask_d = mask_q | mon.done_i;
          if (act) begin
            wd_d = '0;
          end else if (wd_q != WdMax) begin
            wd_d = wd_q + CntWidth'(1);
          end
          // completion beats a coincident timeout
          if (&mask_d) begin
            state_d = EosDone;
          end else if (to_hit) begin
            state_d = EosTimeout;
          end
        end
        default: ;
      endcase
    end
    stall_d = (state_d == EosTimeout) ? ~mask_d : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EosIdle;
      mask_q     <= '0;
      stall_q    <= '0;
      wd_q       <= '0;
      all_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      stall_q    <= stall_d;
      wd_q       <= wd_d;
      all_done_q <= (state_d == EosDone);
      timeout_q  <= (state_d == EosTimeout);
    end
  end

  for (genvar i = 0; i < NumChannels; i++) begin : g_beat
    floo_sat_counter #(
      .CntWidth (CntWidth)
    ) u_beat (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (mon.start_i),
      .en_i   (run_en & mon.progress_i[i]),
      .cnt_o  (beat_cnt[i])
    );
  end

  floo_sat_counter #(
    .CntWidth (CntWidth)
  ) u_runtime (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (mon.start_i),
    .en_i   (run_en),
    .cnt_o  (runtime)
  );

  assign mon.done_mask_o    = mask_q;
  assign mon.beat_cnt_o     = beat_cnt;
  assign mon.runtime_o      = runtime;
  assign mon.all_done_o     = all_done_q;
  assign mon.timeout_o      = timeout_q;
  assign mon.stalled_mask_o = stall_q;

endmodule
